lock_sequencer: RTL

Clocked controller that sequences keypad entry for the digital lock. It tracks unlock and reprogram sessions from single-cycle key events and enforces code length rules. It stores and compares the user code, counts failed attempts and drives the lockout. It sits between the debounced keypad decoder and the lock actuator/status LEDs.

---
 rtl/lock_pkg.sv | 29 ++
 rtl/code_buffer.sv | 60 ++++++
 rtl/lock_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared constants and types for the keypad lock sequencer.
//   DIGIT_W           : bits per entered digit
//   KEY_*             : key codes with a control meaning
//   state_t           : sequencer state encoding (also driven on state_o)
//   is_digit()        : true for keys 0..6
package lock_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] KEY_MAX_DIGIT = 4'd6;
    localparam logic [DIGIT_W-1:0] KEY_CLEAR     = 4'd7;
    localparam logic [DIGIT_W-1:0] KEY_PROG      = 4'd8;
    localparam logic [DIGIT_W-1:0] KEY_ENTER     = 4'd9;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        READ_LOCK    = 3'd1,
        READ_ADMIN   = 3'd2,
        READ_NEW     = 3'd3,
        READ_CONFIRM = 3'd4,
        LOCKOUT      = 3'd5,
        OPEN         = 3'd6
    } state_t;

    function automatic logic is_digit(input logic [DIGIT_W-1:0] k);
        return (k <= KEY_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/code_buffer.sv
// Digit code register: shift-in entry, parallel load, length count,
// overflow flag and equality compare against a reference code.
//   clk, rst    : clock, synchronous active-high reset
//   clr         : empty the buffer (count 0, ovf 0)
//   shift       : append digit at the least significant end
//   digit       : digit to append
//   load        : parallel load of load_data / load_len (ovf cleared)
//   ref_data    : reference code, right-aligned
//   ref_len     : reference code length in digits
//   data        : held digits, right-aligned, MSD first
//   count       : number of held digits (saturates at MAX_LEN)
//   ovf         : a digit arrived while already full
//   match_c     : combinational; buffer equals reference and not overflowed
module code_buffer
    import lock_pkg::*;
#(
    parameter  int unsigned MAX_LEN = 6,
    localparam int unsigned CODE_W  = MAX_LEN * DIGIT_W,
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               load,
    input  logic [CODE_W-1:0]  load_data,
    input  logic [CNT_W-1:0]   load_len,
    input  logic [CODE_W-1:0]  ref_data,
    input  logic [CNT_W-1:0]   ref_len,
    output logic [CODE_W-1:0]  data,
    output logic [CNT_W-1:0]   count,
    output logic               ovf,
    output logic               match_c
);

    // Storage; once full, extra digits only raise ovf so the entry can never match.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            count <= load_len;
            ovf   <= 1'b0;
        end else if (shift) begin
            if (count == CNT_W'(MAX_LEN)) begin
                ovf <= 1'b1;
            end else begin
                data  <= {data[CODE_W-DIGIT_W-1:0], digit};
                count <= count + CNT_W'(1);
            end
        end
    end

    // Codes are right-aligned with zero fill, so equal length plus equal data is exact.
    assign match_c = !ovf && (count == ref_len) && (data == ref_data);

endmodule

// File: rtl/lock_sequencer.sv
// Keypad lock sequencer: unlock and reprogram sessions, code storage,
// failed-attempt counting, lockout and unlock hold timing.
//   clk, rst   : clock, synchronous active-high reset
//   key_valid  : one-cycle strobe qualifying key
//   key        : 0-6 digit, 7 CLEAR, 8 PROG, 9 ENTER, 10-15 ignored
//   unlocked   : lock released (registered)
//   prog_done  : one-cycle pulse, new user code committed
//   error      : one-cycle pulse, entry rejected
//   lockout    : high while locked out after too many failures
//   state_o    : current state encoding
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned                   MIN_LEN        = 4,
    parameter int unsigned                   MAX_LEN        = 6,
    parameter logic [MAX_LEN*DIGIT_W-1:0]    DEFAULT_CODE   = 24'h123456,
    parameter int unsigned                   DEFAULT_LEN    = 6,
    parameter logic [MAX_LEN*DIGIT_W-1:0]    ADMIN_CODE     = 24'h654321,
    parameter int unsigned                   MAX_FAILS      = 3,
    parameter int unsigned                   LOCKOUT_CYCLES = 1000,
    parameter int unsigned                   UNLOCK_CYCLES  = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic       unlocked,
    output logic       prog_done,
    output logic       error,
    output logic       lockout,
    output logic [2:0] state_o
);

    localparam int unsigned CODE_W  = MAX_LEN * DIGIT_W;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int unsigned TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES
                                                                       : UNLOCK_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_t              state;
    state_t              next_state;

    logic [CODE_W-1:0]   entry_data;
    logic [CNT_W-1:0]    entry_count;
    logic                entry_ovf;
    logic                entry_match_c;
    logic [CODE_W-1:0]   cand_data;
    logic [CNT_W-1:0]    cand_count;
    logic                cand_ovf;
    logic                cand_match_c;

    logic [CODE_W-1:0]   stored_code;
    logic [CNT_W-1:0]    stored_len;
    logic [CODE_W-1:0]   ref_data_c;
    logic [CNT_W-1:0]    ref_len_c;

    logic [FAIL_W-1:0]   fail_cnt;
    logic [TMR_W-1:0]    timer;

    logic                in_read_c;
    logic                entry_shift_c;
    logic                entry_clr_c;
    logic                cand_clr_c;
    logic                cand_load_c;
    logic                commit_c;
    logic                err_c;
    logic                done_c;
    logic                fail_inc_c;
    logic                fail_clr_c;
    logic                tmr_load_c;
    logic [TMR_W-1:0]    tmr_val_c;
    logic                confirm_ok_c;
    logic                len_ok_c;
    state_t              fail_dest_c;

    // Entry buffer: digits typed in the current session.
    code_buffer #(.MAX_LEN(MAX_LEN)) u_entry (
        .clk       (clk),
        .rst       (rst),
        .clr       (entry_clr_c),
        .shift     (entry_shift_c),
        .digit     (key),
        .load      (1'b0),
        .load_data ('0),
        .load_len  ('0),
        .ref_data  (ref_data_c),
        .ref_len   (ref_len_c),
        .data      (entry_data),
        .count     (entry_count),
        .ovf       (entry_ovf),
        .match_c   (entry_match_c)
    );

    // Candidate buffer: new code awaiting confirmation, compared against the entry.
    code_buffer #(.MAX_LEN(MAX_LEN)) u_cand (
        .clk       (clk),
        .rst       (rst),
        .clr       (cand_clr_c),
        .shift     (1'b0),
        .digit     ('0),
        .load      (cand_load_c),
        .load_data (entry_data),
        .load_len  (entry_count),
        .ref_data  (entry_data),
        .ref_len   (entry_count),
        .data      (cand_data),
        .count     (cand_count),
        .ovf       (cand_ovf),
        .match_c   (cand_match_c)
    );

    // Reference for the entry compare: admin code while authenticating, else user code.
    always_comb begin
        ref_data_c = stored_code;
        ref_len_c  = stored_len;
        if (state == READ_ADMIN) begin
            ref_data_c = ADMIN_CODE;
            ref_len_c  = CNT_W'(MAX_LEN);
        end
    end

    assign in_read_c     = (state == READ_LOCK) || (state == READ_ADMIN) ||
                           (state == READ_NEW)  || (state == READ_CONFIRM);
    assign entry_shift_c = key_valid && in_read_c && is_digit(key);
    assign confirm_ok_c  = cand_match_c && !entry_ovf;
    assign len_ok_c      = !entry_ovf && (entry_count >= CNT_W'(MIN_LEN));
    assign fail_dest_c   = (fail_cnt >= FAIL_W'(MAX_FAILS - 1)) ? LOCKOUT : IDLE;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and session control
    always_comb begin
        next_state  = state;
        cand_load_c = 1'b0;
        commit_c    = 1'b0;
        err_c       = 1'b0;
        done_c      = 1'b0;
        fail_inc_c  = 1'b0;
        fail_clr_c  = 1'b0;
        tmr_load_c  = 1'b0;
        tmr_val_c   = '0;

        case (state)
            IDLE: begin
                if (key_valid && (key == KEY_ENTER)) begin
                    next_state = READ_LOCK;
                end else if (key_valid && (key == KEY_PROG)) begin
                    next_state = READ_ADMIN;
                end
            end

            READ_LOCK: begin
                if (key_valid && (key == KEY_CLEAR)) begin
                    next_state = IDLE;
                end else if (key_valid && (key == KEY_ENTER)) begin
                    if (entry_match_c) begin
                        next_state = OPEN;
                        fail_clr_c = 1'b1;
                    end else begin
                        err_c      = 1'b1;
                        fail_inc_c = 1'b1;
                        next_state = fail_dest_c;
                    end
                end else if (key_valid && (key == KEY_PROG)) begin
                    err_c      = 1'b1;
                    next_state = IDLE;
                end
            end

            READ_ADMIN: begin
                if (key_valid && (key == KEY_CLEAR)) begin
                    next_state = IDLE;
                end else if (key_valid && (key == KEY_PROG)) begin
                    if (entry_match_c) begin
                        next_state = READ_NEW;
                    end else begin
                        err_c      = 1'b1;
                        fail_inc_c = 1'b1;
                        next_state = fail_dest_c;
                    end
                end else if (key_valid && (key == KEY_ENTER)) begin
                    err_c      = 1'b1;
                    next_state = IDLE;
                end
            end

            READ_NEW: begin
                if (key_valid && (key == KEY_CLEAR)) begin
                    next_state = IDLE;
                end else if (key_valid && (key == KEY_PROG)) begin
                    if (len_ok_c) begin
                        cand_load_c = 1'b1;
                        next_state  = READ_CONFIRM;
                    end else begin
                        err_c      = 1'b1;
                        next_state = IDLE;
                    end
                end else if (key_valid && (key == KEY_ENTER)) begin
                    err_c      = 1'b1;
                    next_state = IDLE;
                end
            end

            READ_CONFIRM: begin
                if (key_valid && (key == KEY_CLEAR)) begin
                    next_state = IDLE;
                end else if (key_valid && (key == KEY_PROG)) begin
                    if (confirm_ok_c) begin
                        commit_c = 1'b1;
                        done_c   = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                    next_state = IDLE;
                end else if (key_valid && (key == KEY_ENTER)) begin
                    err_c      = 1'b1;
                    next_state = IDLE;
                end
            end

            OPEN: begin
                if ((key_valid && (key == KEY_ENTER)) || (timer == '0)) begin
                    next_state = IDLE;
                end
            end

            LOCKOUT: begin
                if (timer == '0) begin
                    next_state = IDLE;
                    fail_clr_c = 1'b1;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase

        // Timer loads with N-1 so the state is held for exactly N cycles.
        if ((next_state != state) && (next_state == OPEN)) begin
            tmr_load_c = 1'b1;
            tmr_val_c  = TMR_W'(UNLOCK_CYCLES - 1);
        end else if ((next_state != state) && (next_state == LOCKOUT)) begin
            tmr_load_c = 1'b1;
            tmr_val_c  = TMR_W'(LOCKOUT_CYCLES - 1);
        end
    end

    // Every session transition starts the next digit sequence from empty.
    assign entry_clr_c = (next_state != state);
    assign cand_clr_c  = (next_state == IDLE) && (state != IDLE);

    // User code storage
    always_ff @(posedge clk) begin
        if (rst) begin
            stored_code <= DEFAULT_CODE;
            stored_len  <= CNT_W'(DEFAULT_LEN);
        end else if (commit_c) begin
            stored_code <= cand_data;
            stored_len  <= cand_count;
        end
    end

    // Consecutive failure counter
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt <= '0;
        end else if (fail_clr_c) begin
            fail_cnt <= '0;
        end else if (fail_inc_c) begin
            fail_cnt <= fail_cnt + FAIL_W'(1);
        end
    end

    // Shared down-counter for OPEN and LOCKOUT
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (tmr_load_c) begin
            timer <= tmr_val_c;
        end else if (timer != '0) begin
            timer <= timer - TMR_W'(1);
        end
    end

    // Registered outputs, aligned with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            unlocked  <= 1'b0;
            lockout   <= 1'b0;
            error     <= 1'b0;
            prog_done <= 1'b0;
        end else begin
            unlocked  <= (next_state == OPEN);
            lockout   <= (next_state == LOCKOUT);
            error     <= err_c;
            prog_done <= done_c;
        end
    end

    assign state_o = state;

endmodule
